// File: rtl/lsop_defs.sv
// lsop_defs: load/store op codes, stall vectors and bus FSM states shared by the bus controller
package lsop_defs;
  typedef enum logic [3:0] {
    NOP = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4,
    LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8
  } lsop_e;
  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_DATA  = 6'b011111;
  localparam logic [5:0] STALL_EX    = 6'b001111;
  localparam logic [5:0] STALL_ID    = 6'b000111;
  localparam logic [5:0] STALL_FETCH = 6'b000011;
  typedef enum logic [2:0] {IDLE, D_WAIT, D_DONE, I_WAIT, I_DONE} state_e;
endpackage

// File: rtl/ls_align.sv
// ls_align: byte-lane select, store replication, load extension and misalignment detect
module ls_align
  import lsop_defs::*;
(
  input  logic [3:0]  lsop,
  input  logic [1:0]  off,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        we,
  output logic        misalign
);
  logic        is_byte, is_half, is_word;
  logic [31:0] sh;
  always_comb begin
    is_byte   = lsop == LB || lsop == LBU || lsop == SB;
    is_half   = lsop == LH || lsop == LHU || lsop == SH;
    is_word   = lsop == LW || lsop == SW;
    sh        = rdata >> {off, 3'b000};
    sel       = is_byte ? 4'b0001 << off : is_half ? 4'b0011 << off : 4'b1111;
    wdata     = lsop == SB ? {4{reg2[7:0]}} : lsop == SH ? {2{reg2[15:0]}} : reg2;
    rdata_ext = lsop == LB  ? {{24{sh[7]}}, sh[7:0]} :
                lsop == LBU ? {24'd0, sh[7:0]} :
                lsop == LH  ? {{16{sh[15]}}, sh[15:0]} :
                lsop == LHU ? {16'd0, sh[15:0]} :
                lsop == LW  ? rdata : 32'd0;
    we        = lsop inside {SB, SH, SW};
    misalign  = (is_half && off[0]) || (is_word && off != 2'b00);
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-port bus arbiter for fetch and load/store with pipeline stall generation
module mem_bus_ctrl
  import lsop_defs::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mem_lsop,
  input  logic [31:0] mem_memaddr,
  input  logic [31:0] mem_reg2,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  output logic [5:0]  stall,
  output logic [31:0] mem_rdata,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        exc_misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [3:0]        op_q, op_d, ls_op, sel;
  logic [1:0]        off_q, off_d, ls_off;
  logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d, if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d, exc_misalign_q, exc_misalign_d, bus_err_q, bus_err_d;
  logic [31:0]       wdata, rdata_ext;
  logic              we, misalign, dat, fin;
  // The op under way is held locally so extension stays correct while the pipeline is frozen.
  assign ls_op  = state_q == IDLE ? mem_lsop : op_q;
  assign ls_off = state_q == IDLE ? mem_memaddr[1:0] : off_q;
  ls_align u_align (
    .lsop(ls_op), .off(ls_off), .reg2(mem_reg2), .rdata(bus_rdata),
    .sel(sel), .wdata(wdata), .rdata_ext(rdata_ext), .we(we), .misalign(misalign)
  );
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    off_d          = off_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_sel_d      = bus_sel_q;
    mem_rdata_d    = mem_rdata_q;
    if_inst_d      = if_inst_q;
    if_valid_d     = 1'b0;
    exc_misalign_d = 1'b0;
    bus_err_d      = 1'b0;
    dat            = state_q == D_WAIT;
    fin            = bus_ack || cnt_q == TO_LAST;
    case (state_q)
      IDLE: begin
        if (mem_lsop != NOP) begin
          op_d  = mem_lsop;
          off_d = mem_memaddr[1:0];
          cnt_d = '0;
          if (misalign) begin
            state_d        = D_DONE;
            exc_misalign_d = 1'b1;
            mem_rdata_d    = 32'd0;
          end else begin
            state_d     = D_WAIT;
            bus_req_d   = 1'b1;
            bus_we_d    = we;
            bus_addr_d  = mem_memaddr & 32'hFFFF_FFFC;
            bus_wdata_d = wdata;
            bus_sel_d   = sel;
          end
        end else if (if_req) begin
          state_d    = I_WAIT;
          cnt_d      = '0;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr & 32'hFFFF_FFFC;
          bus_sel_d  = 4'b1111;
        end
      end
      D_WAIT, I_WAIT: begin
        if (fin) begin
          state_d     = dat ? D_DONE : I_DONE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_err_d   = !bus_ack;
          mem_rdata_d = dat ? (bus_ack ? rdata_ext : 32'd0) : mem_rdata_q;
          if_inst_d   = dat ? if_inst_q : (bus_ack ? bus_rdata : 32'd0);
          if_valid_d  = !dat;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Done states add nothing, so a completed op advances exactly once.
  always_comb begin
    stall = (((state_q == IDLE && mem_lsop != NOP) || state_q == D_WAIT) ? STALL_DATA : STALL_NONE) |
            (((state_q == IDLE && mem_lsop == NOP && if_req) || state_q == I_WAIT) ? STALL_FETCH : STALL_NONE) |
            (stallreq_ex ? STALL_EX : STALL_NONE) |
            (stallreq_id ? STALL_ID : STALL_NONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      off_q          <= '0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_sel_q      <= '0;
      mem_rdata_q    <= '0;
      if_inst_q      <= '0;
      if_valid_q     <= 1'b0;
      exc_misalign_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      off_q          <= off_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_sel_q      <= bus_sel_d;
      mem_rdata_q    <= mem_rdata_d;
      if_inst_q      <= if_inst_d;
      if_valid_q     <= if_valid_d;
      exc_misalign_q <= exc_misalign_d;
      bus_err_q      <= bus_err_d;
    end
  end
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_sel      = bus_sel_q;
  assign mem_rdata    = mem_rdata_q;
  assign if_inst      = if_inst_q;
  assign if_valid     = if_valid_q;
  assign exc_misalign = exc_misalign_q;
  assign bus_err      = bus_err_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed scoreboard bench for the shared fetch/load-store bus controller
module tb_mem_bus_ctrl;
  import lsop_defs::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  mem_lsop = '0;
  logic [31:0] mem_memaddr = '0, mem_reg2 = '0, if_addr = '0, bus_rdata = '0;
  logic        if_req = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, bus_ack = 1'b0;
  logic [5:0]  stall;
  logic [31:0] mem_rdata, if_inst, bus_addr, bus_wdata;
  logic        if_valid, exc_misalign, bus_err, bus_req, bus_we;
  logic [3:0]  bus_sel;
  int          n_chk = 0, n_err = 0;
  typedef struct {
    string       tag;
    logic [31:0] rdata, addr, wdata;
    logic [3:0]  sel;
    logic        we, mis;
    int          stalls;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] inst_q[$];
  mem_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_lsop(mem_lsop), .mem_memaddr(mem_memaddr), .mem_reg2(mem_reg2),
    .if_req(if_req), .if_addr(if_addr), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stall(stall), .mem_rdata(mem_rdata), .if_inst(if_inst), .if_valid(if_valid),
    .exc_misalign(exc_misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic data_op(input string tag, input logic [3:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rdata, input int waits, input logic [31:0] x_rdata,
                         input logic [31:0] x_addr, input logic [31:0] x_wdata, input logic [3:0] x_sel,
                         input logic x_we, input logic x_mis);
    exp_t e;
    int   st = 0, w = 0;
    logic seen = 1'b0, done = 1'b0;
    e.tag = tag; e.rdata = x_rdata; e.addr = x_addr; e.wdata = x_wdata; e.sel = x_sel;
    e.we = x_we; e.mis = x_mis; e.stalls = x_mis ? 1 : waits + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    mem_lsop = op; mem_memaddr = addr; mem_reg2 = reg2;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall == 6'd0) done = 1'b1;
      else begin
        st++;
        if (bus_req) begin
          if (!seen) begin
            seen = 1'b1;
            chk({sb[0].tag, " addr"}, bus_addr, sb[0].addr);
            chk({sb[0].tag, " sel"}, 32'(bus_sel), 32'(sb[0].sel));
            chk({sb[0].tag, " we"}, 32'(bus_we), 32'(sb[0].we));
            if (sb[0].we) chk({sb[0].tag, " wdata"}, bus_wdata, sb[0].wdata);
          end
          bus_ack = (w == waits);
          bus_rdata = rdata;
          w++;
        end
      end
    end
    e = sb.pop_front();
    chk({e.tag, " completed"}, 32'(done), 32'd1);
    chk({e.tag, " stall cycles"}, 32'(st), 32'(e.stalls));
    chk({e.tag, " rdata"}, mem_rdata, e.rdata);
    chk({e.tag, " misalign"}, 32'(exc_misalign), 32'(e.mis));
    chk({e.tag, " bus cycle"}, 32'(seen), 32'(!e.mis));
    chk({e.tag, " req dropped"}, 32'(bus_req), 32'd0);
    chk({e.tag, " no err"}, 32'(bus_err), 32'd0);
    mem_lsop = '0; bus_ack = 1'b0;
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_sel", 32'(bus_sel), 32'd0);
    chk("rst mem_rdata", mem_rdata, 32'd0);
    chk("rst if_inst", if_inst, 32'd0);
    chk("rst flags", 32'({if_valid, exc_misalign, bus_err, bus_we}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1 stallreq_ex = 1'b1;
    @(negedge clk); chk("stall ex", 32'(stall), 32'(6'b001111));
    @(posedge clk); #1 stallreq_ex = 1'b0; stallreq_id = 1'b1;
    @(negedge clk); chk("stall id", 32'(stall), 32'(6'b000111));
    @(posedge clk); #1 stallreq_ex = 1'b1;
    @(negedge clk); chk("stall id+ex", 32'(stall), 32'(6'b001111));
    @(posedge clk); #1 stallreq_ex = 1'b0; stallreq_id = 1'b0;
    data_op("LW 100", LW, 32'h100, 32'h0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 32'h100, 32'h0, 4'b1111, 1'b0, 1'b0);
    data_op("LB 103", LB, 32'h103, 32'h0, 32'h80000000, 0, 32'hFFFFFF80, 32'h100, 32'h0, 4'b1000, 1'b0, 1'b0);
    data_op("LBU 103", LBU, 32'h103, 32'h0, 32'h80000000, 0, 32'h00000080, 32'h100, 32'h0, 4'b1000, 1'b0, 1'b0);
    data_op("LH 102", LH, 32'h102, 32'h0, 32'h80011234, 1, 32'hFFFF8001, 32'h100, 32'h0, 4'b1100, 1'b0, 1'b0);
    data_op("LHU 100", LHU, 32'h100, 32'h0, 32'h80019234, 0, 32'h00009234, 32'h100, 32'h0, 4'b0011, 1'b0, 1'b0);
    data_op("SH 202", SH, 32'h202, 32'h1234ABCD, 32'h0, 0, 32'h0, 32'h200, 32'hABCDABCD, 4'b1100, 1'b1, 1'b0);
    data_op("SB 201", SB, 32'h201, 32'h000000EF, 32'h0, 1, 32'h0, 32'h200, 32'hEFEFEFEF, 4'b0010, 1'b1, 1'b0);
    data_op("LW 101", LW, 32'h101, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1);
    data_op("SH 203", SH, 32'h203, 32'h5555, 32'h0, 0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1);
    inst_q.push_back(32'hCAFEF00D);
    @(posedge clk); #1;
    mem_lsop = LW; mem_memaddr = 32'h300; if_req = 1'b1; if_addr = 32'h400;
    @(negedge clk); chk("arb data stall", 32'(stall), 32'(6'b011111));
    @(negedge clk); chk("arb data addr", bus_addr, 32'h300);
    bus_ack = 1'b1; bus_rdata = 32'h11112222;
    @(negedge clk); chk("arb data rdata", mem_rdata, 32'h11112222);
    chk("arb done stall", 32'(stall), 32'd0);
    mem_lsop = '0; bus_ack = 1'b0;
    @(negedge clk); chk("arb fetch stall", 32'(stall), 32'(6'b000011));
    @(negedge clk); chk("arb fetch addr", bus_addr, 32'h400);
    chk("arb fetch sel", 32'(bus_sel), 32'hF);
    chk("arb fetch we", 32'(bus_we), 32'd0);
    bus_ack = 1'b1; bus_rdata = inst_q[0];
    @(negedge clk); chk("arb if_valid", 32'(if_valid), 32'd1);
    chk("arb if_inst", if_inst, inst_q.pop_front());
    chk("arb idone stall", 32'(stall), 32'd0);
    if_req = 1'b0; bus_ack = 1'b0;
    @(negedge clk); chk("arb if_valid pulse", 32'(if_valid), 32'd0);
    @(posedge clk); #1 mem_lsop = LW; mem_memaddr = 32'h500;
    n = 0;
    for (int c = 0; c < 400 && !bus_err; c++) begin
      @(negedge clk);
      if (bus_req) n++;
    end
    chk("to bus_err", 32'(bus_err), 32'd1);
    chk("to wait cycles", 32'(n), 32'd255);
    chk("to rdata", mem_rdata, 32'd0);
    chk("to stall", 32'(stall), 32'd0);
    mem_lsop = '0;
    @(negedge clk); chk("to err pulse", 32'(bus_err), 32'd0);
    chk("to idle req", 32'(bus_req), 32'd0);
    @(posedge clk); #1 mem_lsop = LW; mem_memaddr = 32'h600;
    @(negedge clk); @(negedge clk); chk("rst mid req", 32'(bus_req), 32'd1);
    rst_n = 1'b0; mem_lsop = '0;
    @(negedge clk); chk("rst mid req low", 32'(bus_req), 32'd0);
    chk("rst mid stall", 32'(stall), 32'd0);
    rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk); chk("stray ack req", 32'(bus_req), 32'd0);
    chk("stray ack rdata", mem_rdata, 32'd0);
    chk("stray ack flags", 32'({if_valid, bus_err, exc_misalign}), 32'd0);
    bus_ack = 1'b0;
    @(negedge clk); chk("stray ack stall", 32'(stall), 32'd0);
    data_op("LW 700", LW, 32'h700, 32'h0, 32'h0BADF00D, 1, 32'h0BADF00D, 32'h700, 32'h0, 4'b1111, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
